muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide responder for the 32-bit MIPS datapath.
- Executes mult, multu, div and divu. Holds the architectural HI/LO registers, so the datapath can serve mfhi/mflo/mthi/mtlo from it.
- The datapath is the initiator: it issues a start/op pair and waits on busy/done.
- Complements the combinational ALU, which has no multiply or divide path.

Parameters:
- WIDTH, 32, operand and HI/LO width
- ITER, 32, iteration count per operation (one result bit per cycle); must equal WIDTH

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request; accepted only in IDLE
- op  input  2  00 multu, 01 mult, 10 divu, 11 div; sampled with start
- alu_src1  input  32  multiplicand / dividend; sampled with start
- alu_src2  input  32  multiplier / divisor; sampled with start
- hi_we  input  1  mthi write, honoured only in IDLE
- lo_we  input  1  mtlo write, honoured only in IDLE
- wr_data  input  32  data for hi_we/lo_we
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; hi/lo are valid in that same cycle
- hi  output  32  HI register (product[63:32] or remainder)
- lo  output  32  LO register (product[31:0] or quotient)
- div_by_zero  output  1  set with done when a divide had alu_src2==0; cleared on next accepted start

Behaviour:
- Reset, synchronous and active-high, is sampled on clk rising edge:
  - state=IDLE
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0
  - iteration counter=0
  - Reset mid-operation abandons the operation with no partial HI/LO update.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 → latch op. For signed ops, latch operand magnitudes and result signs. Set count=0, go to CALC.
  - hi_we/lo_we write wr_data into hi/lo. A write and start in the same cycle: both occur, write first. The result later overwrites HI/LO.
- CALC: one step per cycle, count 0..ITER-1, then go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per step. A 33-bit trial subtract sets the quotient bit when the remainder ≥ divisor.
- FIX, one cycle, applies signs:
  - Product is negated if sign1^sign2.
  - Quotient is negated if sign1^sign2.
  - Remainder takes the dividend's sign.
  - Divisor==0 overrides: lo=32'hFFFFFFFF, hi=original alu_src1 (signed and unsigned alike), div_by_zero=1. Unsigned restoring division produces this result naturally.
- DONE, one cycle:
  - hi/lo are written and done=1.
  - Returns to IDLE next cycle, so back-to-back start is accepted in the cycle after done.
- busy=1 in CALC, FIX and DONE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+ITER+1, i.e. 34 cycles of busy for ITER=32.
- start while busy is ignored, with no queueing. op and operand changes during busy have no effect.
- Arithmetic:
  - Operands are two's complement for mult/div.
  - 0x80000000 magnitude is represented in 33 bits, so no overflow occurs.
  - div 0x80000000 / -1 → lo=0x80000000, hi=0 (wraps, no flag).
- HI/LO keep their values until the next done, hi_we/lo_we write, or reset.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - FSM state typedef and encoding
  - ITER constant
- One natural sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: accumulator, divisor/multiplicand, mode.
  - Outputs: next accumulator.
  - The top module keeps the FSM, counter, sign logic and HI/LO registers.

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Busy for 34 cycles, done is a single-cycle pulse.
- mult −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; then mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- divu 7/2 → lo=3, hi=1; div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/−1 → lo=0x80000000, hi=0.
- divu 5/0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1; next start (multu 2×3) clears the flag → lo=6.
- start pulsed at cycles 5 and 20 of a running divide → both ignored, one done only. Reset asserted at cycle 10 of a divide → busy=0, hi=lo=0 next cycle, no done.
- lo_we wr_data=0x1234 in IDLE → lo=0x1234. lo_we during busy → ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITER  = MD_WIDTH;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Datapath-to-muldiv request/response bundle; the datapath is the master.
interface muldiv_if;
  import muldiv_pkg::*;

  logic                start;
  op_e                 op;
  logic [MD_WIDTH-1:0] alu_src1;
  logic [MD_WIDTH-1:0] alu_src2;
  logic                hi_we;
  logic                lo_we;
  logic [MD_WIDTH-1:0] wr_data;
  logic                busy;
  logic                done;
  logic [MD_WIDTH-1:0] hi;
  logic [MD_WIDTH-1:0] lo;
  logic                div_by_zero;

  modport master (
    output start, op, alu_src1, alu_src2, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, alu_src1, alu_src2, hi_we, lo_we, wr_data,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply step or restoring divide step on a {hi,lo} accumulator.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted_rem;
  logic           ge;

  always_comb begin
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // remainder shifted left by one with the next dividend bit: a 33-bit trial value
    shifted_rem = acc[2*WIDTH-1:WIDTH-1];
    ge          = (shifted_rem >= {1'b0, operand});
    acc_next_c  = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (ge) acc_next_c = {WIDTH'(shifted_rem - {1'b0, operand}), acc[WIDTH-2:0], 1'b1};
      else    acc_next_c = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu engine holding the architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITER  = MD_ITER
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next_c;
  logic [WIDTH-1:0]   operand_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dbz_q;

  logic               start_div, start_signed, sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quot_c, rem_c, res_hi_c, res_lo_c;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_q),
    .operand    (operand_q),
    .is_div     (is_div_q),
    .acc_next_c (acc_next_c)
  );

  // Operand magnitudes and result signs captured at start
  always_comb begin
    start_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    start_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    sign1        = start_signed && bus.alu_src1[WIDTH-1];
    sign2        = start_signed && bus.alu_src2[WIDTH-1];
    mag1         = sign1 ? -bus.alu_src1 : bus.alu_src1;
    mag2         = sign2 ? -bus.alu_src2 : bus.alu_src2;
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient
  always_comb begin
    prod_c   = neg_res_q ? -acc_q : acc_q;
    quot_c   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_c    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_hi_c = prod_c[2*WIDTH-1:WIDTH];
    res_lo_c = prod_c[WIDTH-1:0];
    if (is_div_q) begin
      res_hi_c = rem_c;
      res_lo_c = dbz_q ? '1 : quot_c;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (count_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      acc_q           <= '0;
      operand_q       <= '0;
      is_div_q        <= 1'b0;
      neg_res_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      dbz_q           <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= (state_d != S_IDLE);
      bus.done <= (state_d == S_DONE);
      unique case (state_q)
        S_IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wr_data;
          if (bus.lo_we) bus.lo <= bus.wr_data;
          if (bus.start) begin
            is_div_q        <= start_div;
            neg_res_q       <= sign1 ^ sign2;
            neg_rem_q       <= sign1;
            dbz_q           <= start_div && (bus.alu_src2 == '0);
            bus.div_by_zero <= 1'b0;
            count_q         <= '0;
            acc_q           <= {WIDTH'(0), mag1};
            operand_q       <= mag2;
          end
        end
        S_CALC: begin
          acc_q   <= acc_next_c;
          count_q <= count_q + CNT_W'(1);
        end
        S_FIX: begin
          bus.hi          <= res_hi_c;
          bus.lo          <= res_lo_c;
          bus.div_by_zero <= dbz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  muldiv_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] b);
    bus.op       = o;
    bus.alu_src1 = a;
    bus.alu_src2 = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Watch up to 60 cycles; optionally pulse a stray start at two cycle numbers.
  task automatic wait_result(input int inj_a, input int inj_b, output int busy_cyc,
                             output int done_cnt, output logic [31:0] h,
                             output logic [31:0] l, output logic dz);
    busy_cyc = 0;
    done_cnt = 0;
    h  = '0;
    l  = '0;
    dz = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        h  = bus.hi;
        l  = bus.lo;
        dz = bus.div_by_zero;
      end
      if (cyc == inj_a || cyc == inj_b) begin
        bus.start    = 1'b1;
        bus.op       = OP_MULTU;
        bus.alu_src1 = 32'd3;
        bus.alu_src2 = 32'd3;
      end
      if (inj_a == 0 && done_cnt > 0 && !bus.busy) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 00000000", bus.lo); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_hilo_write();
    bus.lo_we = 1'b1; bus.wr_data = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we = 1'b0; bus.hi_we = 1'b1; bus.wr_data = 32'h0000_ABCD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    vectors++; if (bus.lo !== 32'h0000_1234) begin miscompares++; $display("FAIL mtlo got %h want 00001234", bus.lo); end
    vectors++; if (bus.hi !== 32'h0000_ABCD) begin miscompares++; $display("FAIL mthi got %h want 0000abcd", bus.hi); end
  endtask

  task automatic test_multu_timing();
    int bc, dc; logic [31:0] h, l; logic dz;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(0, 0, bc, dc, h, l, dz);
    vectors++; if (h !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", h); end
    vectors++; if (l !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", l); end
    vectors++; if (bc != 34) begin miscompares++; $display("FAIL multu_busy_cycles got %0d want 34", bc); end
    vectors++; if (dc != 1) begin miscompares++; $display("FAIL multu_done_pulses got %0d want 1", dc); end
  endtask

  task automatic test_arith();
    op_e         ops [7] = '{OP_MULT, OP_MULT, OP_MULTU, OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
    logic [31:0] src1[7] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_0000, 32'd7,
                             32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [31:0] src2[7] = '{32'd7, 32'h8000_0000, 32'h0001_0000, 32'd2,
                             32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] exp_hi[7] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0001, 32'd1,
                               32'hFFFF_FFFF, 32'h0, 32'd1};
    logic [31:0] exp_lo[7] = '{32'hFFFF_FFEB, 32'h0, 32'h0, 32'd3,
                               32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD};
    int bc, dc; logic [31:0] h, l; logic dz;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], src1[i], src2[i]);
      wait_result(0, 0, bc, dc, h, l, dz);
      vectors++; if (h !== exp_hi[i]) begin miscompares++; $display("FAIL arith%0d_hi got %h want %h", i, h, exp_hi[i]); end
      vectors++; if (l !== exp_lo[i]) begin miscompares++; $display("FAIL arith%0d_lo got %h want %h", i, l, exp_lo[i]); end
      vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL arith%0d_dbz got %b want 0", i, dz); end
      vectors++; if (dc != 1) begin miscompares++; $display("FAIL arith%0d_done got %0d want 1", i, dc); end
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc; logic [31:0] h, l; logic dz;
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_result(0, 0, bc, dc, h, l, dz);
    vectors++; if (l !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dbz_lo got %h want ffffffff", l); end
    vectors++; if (h !== 32'd5) begin miscompares++; $display("FAIL dbz_hi got %h want 00000005", h); end
    vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dbz_flag got %b want 1", dz); end
    issue(OP_MULTU, 32'd2, 32'd3);
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got busy %b want 1", bus.busy); end
    vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); end
    wait_result(0, 0, bc, dc, h, l, dz);
    vectors++; if (l !== 32'd6) begin miscompares++; $display("FAIL b2b_lo got %h want 00000006", l); end
    vectors++; if (h !== 32'd0) begin miscompares++; $display("FAIL b2b_hi got %h want 00000000", h); end
  endtask

  task automatic test_mtlo_busy();
    int bc, dc; logic [31:0] h, l; logic dz;
    bus.lo_we = 1'b1; bus.wr_data = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    issue(OP_MULTU, 32'd4, 32'd5);
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wr_data = 32'h0000_DEAD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    vectors++; if (bus.lo !== 32'h0000_1234) begin miscompares++; $display("FAIL mtlo_busy got %h want 00001234", bus.lo); end
    wait_result(0, 0, bc, dc, h, l, dz);
    vectors++; if (l !== 32'd20) begin miscompares++; $display("FAIL mtlo_busy_result got %h want 00000014", l); end
  endtask

  task automatic test_busy_start();
    int bc, dc; logic [31:0] h, l; logic dz;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_result(5, 20, bc, dc, h, l, dz);
    vectors++; if (dc != 1) begin miscompares++; $display("FAIL ignore_start_done got %0d want 1", dc); end
    vectors++; if (l !== 32'd14) begin miscompares++; $display("FAIL ignore_start_lo got %h want 0000000e", l); end
    vectors++; if (h !== 32'd2) begin miscompares++; $display("FAIL ignore_start_hi got %h want 00000002", h); end
    vectors++; if (bc != 34) begin miscompares++; $display("FAIL ignore_start_busy got %0d want 34", bc); end
  endtask

  task automatic test_reset_mid_op();
    int dc;
    dc = 0;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL rst_mid_hi got %h want 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL rst_mid_lo got %h want 00000000", bus.lo); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    vectors++; if (dc != 0) begin miscompares++; $display("FAIL rst_mid_done got %0d want 0", dc); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = OP_MULTU;
    bus.alu_src1 = '0;
    bus.alu_src2 = '0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.wr_data  = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_hilo_write();
    test_multu_timing();
    test_arith();
    test_back_to_back();
    test_mtlo_busy();
    test_busy_start();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
